// File: rtl/keypad_matrix_responder_if.sv
// Command channel into the keypad responder: press requests plus early abort.
// Latency: none, wires only.
// Backpressure: cmd_ready from the slave side stalls cmd_valid; nothing is dropped.
//
// Signals:
//   cmd_valid  master->slave  press command present
//   cmd_ready  slave->master  slave can accept a command this cycle
//   cmd_key    master->slave  key index, 0..8 valid
//   cmd_hold   master->slave  closed-contact duration in cycles, 0 behaves as 1
//   cmd_abort  master->slave  force early release of the current press
interface keypad_matrix_responder_if #(
    parameter int HOLD_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic              cmd_abort;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        output cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        input  cmd_abort,
        output cmd_ready
    );
endinterface

// File: rtl/keypad_matrix_responder.sv
// Keypad-side model of a 4x4 row-scan matrix: pulls the column of a commanded key low while its row is scanned.
// Latency: contact closes SETTLE_CYC cycles after accept, stays closed max(hold,1) cycles; column responds to row same cycle.
// Backpressure: cmd_ready is high only in IDLE; a waiting cmd_valid is stalled, never lost.
//
// Ports:
//   clk_100Hz  scan clock, rising edge
//   reset      asynchronous active-low reset
//   cmd        command channel (valid/ready, key, hold, abort), slave side
//   keypadRow  active-low one-cold row select from the scanner
//   keypadCol  active-low column sense, 4'b1111 when no contact
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse when the contact opens (normal end or abort)
//   err        one-cycle pulse after an out-of-range key is accepted
//
// Optional feature: define KEYPAD_BOUNCE_EN to make the contact chatter (closed on even
// offsets, open on odd) during the first min(BOUNCE_CYC, hold) PRESSED cycles.
module keypad_matrix_responder #(
    parameter int SETTLE_CYC = 2,
    parameter int GAP_CYC    = 4,
    parameter int HOLD_W     = 8,
    parameter int BOUNCE_CYC = 6
) (
    input  logic                          clk_100Hz,
    input  logic                          reset,
    keypad_matrix_responder_if.slave      cmd,
    input  logic [3:0]                    keypadRow,
    output logic [3:0]                    keypadCol,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_q;
    logic              done_nxt, err_nxt, load;
    logic              end_press;
    logic [HOLD_W-1:0] hold_eff;
    logic              key_ok;
    logic [3:0]        row_pat, col_pat;
    logic              contact;

    // A zero hold still gives one closed cycle.
    assign hold_eff = (cmd.cmd_hold == '0) ? HOLD_W'(1) : cmd.cmd_hold;
    assign key_ok   = (cmd.cmd_key <= 4'd8);

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    // Next-state logic. end_press collects both ways out of a press (hold expiry and
    // abort) so the done pulse and gap loading live in one place.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        load      = 1'b0;
        end_press = 1'b0;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    if (key_ok) begin
                        load = 1'b1;
                        if (SETTLE_CYC == 0) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = hold_eff;
                        end else begin
                            state_nxt = SETTLE;
                            cnt_nxt   = HOLD_W'(SETTLE_CYC);
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cmd.cmd_abort) begin
                    end_press = 1'b1;
                end else if (cnt <= HOLD_W'(1)) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = hold_q;
                end else begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            PRESSED: begin
                if (cmd.cmd_abort || cnt <= HOLD_W'(1)) begin
                    end_press = 1'b1;
                end else begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            RELEASE: begin
                if (cnt <= HOLD_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (end_press) begin
            done_nxt = 1'b1;
            if (GAP_CYC == 0) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = RELEASE;
                cnt_nxt   = HOLD_W'(GAP_CYC);
            end
        end
    end

    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            key_q  <= '0;
            hold_q <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            if (load) begin
                key_q  <= cmd.cmd_key;
                hold_q <= hold_eff;
            end
        end
    end

    // Row r = key/3, column c = key%3; row/column 3 is never driven.
    always_comb begin
        row_pat = 4'b1111;
        col_pat = 4'b1111;
        case (key_q)
            4'd0: begin row_pat = 4'b1110; col_pat = 4'b1110; end
            4'd1: begin row_pat = 4'b1110; col_pat = 4'b1101; end
            4'd2: begin row_pat = 4'b1110; col_pat = 4'b1011; end
            4'd3: begin row_pat = 4'b1101; col_pat = 4'b1110; end
            4'd4: begin row_pat = 4'b1101; col_pat = 4'b1101; end
            4'd5: begin row_pat = 4'b1101; col_pat = 4'b1011; end
            4'd6: begin row_pat = 4'b1011; col_pat = 4'b1110; end
            4'd7: begin row_pat = 4'b1011; col_pat = 4'b1101; end
            4'd8: begin row_pat = 4'b1011; col_pat = 4'b1011; end
            default: begin row_pat = 4'b1111; col_pat = 4'b1111; end
        endcase
    end

`ifdef KEYPAD_BOUNCE_EN
    // Offset within the current PRESSED phase; restarts at 0 on every entry.
    logic [HOLD_W-1:0] off_q;

    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            off_q <= '0;
        end else if (state == PRESSED && state_nxt == PRESSED) begin
            off_q <= off_q + HOLD_W'(1);
        end else begin
            off_q <= '0;
        end
    end

    // off_q never reaches hold inside PRESSED, so comparing against BOUNCE_CYC alone
    // already yields the min(BOUNCE_CYC, hold) window.
    assign contact = (state == PRESSED) &&
                     ((int'(off_q) >= BOUNCE_CYC) || !off_q[0]);
`else
    wire unused_bounce_cyc = (BOUNCE_CYC != 0);
    assign contact = (state == PRESSED);
`endif

    // Combinational from registered state so the scanner sees the response in the
    // same cycle it drives the row; multi-low rows never match.
    assign keypadCol = (contact && keypadRow == row_pat) ? col_pat : 4'b1111;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
module tb_keypad_matrix_responder;

    logic       clk_100Hz;
    logic       reset;
    logic [3:0] keypadRow;
    logic [3:0] keypadCol;
    logic       busy;
    logic       done;
    logic       err;

    int n_pass;
    int n_total;

    keypad_matrix_responder_if #(.HOLD_W(8)) cmd_if ();

    keypad_matrix_responder #(
        .SETTLE_CYC (2),
        .GAP_CYC    (4),
        .HOLD_W     (8),
        .BOUNCE_CYC (6)
    ) dut (
        .clk_100Hz (clk_100Hz),
        .reset     (reset),
        .cmd       (cmd_if),
        .keypadRow (keypadRow),
        .keypadCol (keypadCol),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk_100Hz = 1'b0;
    always #5 clk_100Hz = ~clk_100Hz;

    typedef struct {
        logic [3:0] key;
        logic [3:0] row;
        logic [3:0] col;
        logic       is_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_100Hz);
        #1;
    endtask

    // Present a command for exactly one accepting edge.
    task automatic send(input logic [3:0] key, input logic [7:0] hold);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_key   = key;
        cmd_if.cmd_hold  = hold;
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_if.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
    endtask

    initial begin
        logic [9:0] pat;
        int         dones;

        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{key: 4'd0,  row: 4'b1110, col: 4'b1110, is_err: 1'b0};
        vecs[1] = '{key: 4'd1,  row: 4'b1110, col: 4'b1101, is_err: 1'b0};
        vecs[2] = '{key: 4'd3,  row: 4'b1101, col: 4'b1110, is_err: 1'b0};
        vecs[3] = '{key: 4'd5,  row: 4'b1101, col: 4'b1011, is_err: 1'b0};
        vecs[4] = '{key: 4'd6,  row: 4'b1011, col: 4'b1110, is_err: 1'b0};
        vecs[5] = '{key: 4'd7,  row: 4'b1011, col: 4'b1101, is_err: 1'b0};
        vecs[6] = '{key: 4'd8,  row: 4'b1011, col: 4'b1011, is_err: 1'b0};
        vecs[7] = '{key: 4'd2,  row: 4'b1101, col: 4'b1111, is_err: 1'b0};
        vecs[8] = '{key: 4'd9,  row: 4'b1110, col: 4'b1111, is_err: 1'b1};
        vecs[9] = '{key: 4'd15, row: 4'b1011, col: 4'b1111, is_err: 1'b1};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_key   = 4'd0;
        cmd_if.cmd_hold  = 8'd0;
        cmd_if.cmd_abort = 1'b0;
        keypadRow        = 4'b1110;
        reset            = 1'b0;

        // Reset state
        #12;
        chk("rst_col",  {4'd0, keypadCol}, 8'b0000_1111);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_err",  {7'd0, err}, 8'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);

        // Key map table: each valid key is checked in its first PRESSED cycle.
        for (int i = 0; i < 10; i++) begin
            wait_ready();
            keypadRow = vecs[i].row;
            send(vecs[i].key, 8'd2);
            if (vecs[i].is_err) begin
                chk($sformatf("tbl_err_k%0d", vecs[i].key), {7'd0, err}, 8'd1);
                chk($sformatf("tbl_busy_k%0d", vecs[i].key), {7'd0, busy}, 8'd0);
                chk($sformatf("tbl_col_k%0d", vecs[i].key), {4'd0, keypadCol}, {4'd0, vecs[i].col});
            end else begin
                tick();
                tick();
                chk($sformatf("tbl_col_k%0d", vecs[i].key), {4'd0, keypadCol}, {4'd0, vecs[i].col});
            end
        end
        wait_ready();

        // 1: key 4, hold 3
        keypadRow = 4'b1101;
        send(4'd4, 8'd3);                      // now cycle T+1
        chk("t1_busy",   {7'd0, busy}, 8'd1);
        chk("t1_ready0", {7'd0, cmd_if.cmd_ready}, 8'd0);
        chk("t1_settle1", {4'd0, keypadCol}, 8'b0000_1111);
        tick();                                 // T+2
        chk("t1_settle2", {4'd0, keypadCol}, 8'b0000_1111);
        tick();                                 // T+3
        chk("t1_p0", {4'd0, keypadCol}, 8'b0000_1101);
        keypadRow = 4'b1110;
        #1 chk("t1_other_row", {4'd0, keypadCol}, 8'b0000_1111);
        keypadRow = 4'b1001;
        #1 chk("t1_multi_low", {4'd0, keypadCol}, 8'b0000_1111);
        keypadRow = 4'b1101;
        tick();                                 // T+4
        chk("t1_p1", {4'd0, keypadCol}, 8'b0000_1101);
        tick();                                 // T+5
        chk("t1_p2", {4'd0, keypadCol}, 8'b0000_1101);
        chk("t1_nodone", {7'd0, done}, 8'd0);
        tick();                                 // T+6
        chk("t1_open", {4'd0, keypadCol}, 8'b0000_1111);
        chk("t1_done", {7'd0, done}, 8'd1);
        tick();                                 // T+7
        chk("t1_done_pulse", {7'd0, done}, 8'd0);
        tick();
        tick();                                 // T+9
        chk("t1_gap_ready", {7'd0, cmd_if.cmd_ready}, 8'd0);
        tick();                                 // T+10
        chk("t1_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        chk("t1_idle", {7'd0, busy}, 8'd0);

        // 2: key 12 is rejected
        keypadRow = 4'b1110;
        send(4'd12, 8'd3);
        chk("t2_err",   {7'd0, err}, 8'd1);
        chk("t2_busy",  {7'd0, busy}, 8'd0);
        chk("t2_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        chk("t2_col",   {4'd0, keypadCol}, 8'b0000_1111);
        tick();
        chk("t2_err_pulse", {7'd0, err}, 8'd0);

        // 3: key 0, hold 0 -> one closed cycle
        keypadRow = 4'b1110;
        send(4'd0, 8'd0);
        tick();
        chk("t3_settle", {4'd0, keypadCol}, 8'b0000_1111);
        tick();
        chk("t3_closed", {4'd0, keypadCol}, 8'b0000_1110);
        chk("t3_nodone", {7'd0, done}, 8'd0);
        tick();
        chk("t3_open", {4'd0, keypadCol}, 8'b0000_1111);
        chk("t3_done", {7'd0, done}, 8'd1);
        wait_ready();

        // 4: key 8, hold 20, abort five cycles into PRESSED
        keypadRow = 4'b1011;
        send(4'd8, 8'd20);
        tick();
        tick();                                 // PRESSED offset 0
        chk("t4_p0", {4'd0, keypadCol}, 8'b0000_1011);
        for (int i = 0; i < 5; i++) tick();     // offset 5
        chk("t4_p5", {4'd0, keypadCol}, 8'b0000_1011);
        cmd_if.cmd_abort = 1'b1;
        tick();
        cmd_if.cmd_abort = 1'b0;
        chk("t4_open", {4'd0, keypadCol}, 8'b0000_1111);
        chk("t4_done", {7'd0, done}, 8'd1);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
            chk($sformatf("t4_gap%0d", i), {7'd0, cmd_if.cmd_ready}, 8'd0);
        end
        tick();
        if (done) dones++;
        chk("t4_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        chk("t4_single_done", dones[7:0], 8'd0);

        // 5: reset in the middle of a press of key 2
        keypadRow = 4'b1110;
        send(4'd2, 8'd10);
        tick();
        tick();
        chk("t5_closed", {4'd0, keypadCol}, 8'b0000_1011);
        reset = 1'b0;
        #1;
        chk("t5_col",  {4'd0, keypadCol}, 8'b0000_1111);
        chk("t5_busy", {7'd0, busy}, 8'd0);
        chk("t5_done", {7'd0, done}, 8'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("t5_nodone_after", {7'd0, done}, 8'd0);
        chk("t5_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        send(4'd1, 8'd1);
        chk("t5_accept", {7'd0, busy}, 8'd1);
        wait_ready();

        // 6: contact pattern across PRESSED for key 5, hold 10 (row 1101, col 1011)
        keypadRow = 4'b1101;
        send(4'd5, 8'd10);
        tick();
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pat[9 - i] = (keypadCol == 4'b1011);
        end
`ifdef KEYPAD_BOUNCE_EN
        chk("t6_bounce_hi", {6'd0, pat[9:8]}, 8'b0000_0010);
        chk("t6_bounce_lo", pat[7:0], 8'b1010_1111);
`else
        chk("t6_steady_hi", {6'd0, pat[9:8]}, 8'b0000_0011);
        chk("t6_steady_lo", pat[7:0], 8'b1111_1111);
`endif
        tick();
        chk("t6_done", {7'd0, done}, 8'd1);
        wait_ready();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
